// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite fetch/serialize path.
package sprite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned TILE_WALL  = 0;
    localparam int unsigned TILE_FLOOR = 1;
    localparam int unsigned SPRITE_W   = 32;
    localparam int unsigned SPRITE_H   = 32;

endpackage

// File: rtl/sprite_row_reader.sv
// Fetches one tile-bitmap row from the sprite ROM and serializes it one pixel
// per pix_en, optionally mirrored horizontally.
module sprite_row_reader
    import sprite_pkg::*;
#(
    parameter int unsigned TILE_BITS  = 1,
    parameter int unsigned ROW_BITS   = $clog2(SPRITE_H),
    parameter int unsigned DATA_WIDTH = SPRITE_W,
    parameter int unsigned ROM_LAT    = 0,
    localparam int unsigned CNT_W     = $clog2(DATA_WIDTH),
    localparam int unsigned ADDR_W    = TILE_BITS + ROW_BITS
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [TILE_BITS-1:0]  tile_id,
    input  logic [ROW_BITS-1:0]   row,
    input  logic                  flip_h,
    input  logic                  pix_en,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  pix_valid,
    output logic                  pix_on,
    output logic [CNT_W-1:0]      pix_col,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    state_t                 state;
    state_t                 state_next;
    logic                   flip;
    logic [DATA_WIDTH-1:0]  sr;
    logic [CNT_W-1:0]       cnt;
    logic [LAT_W-1:0]       wait_cnt;

    logic                   load_req;
    logic                   capture;
    logic                   emit;
    logic                   wait_clr;

    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        capture    = 1'b0;
        emit       = 1'b0;
        wait_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_req   = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (ROM_LAT == 0) begin
                    capture    = 1'b1;
                    state_next = SHIFT;
                end else begin
                    wait_clr   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == LAT_W'(ROM_LAT - 1)) begin
                    capture    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (pix_en) begin
                    emit = 1'b1;
                    // Terminal compare on the last column, so cnt never needs to wrap.
                    if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state == FETCH) || (state == WAIT) || (state == SHIFT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            rom_addr  <= '0;
            flip      <= 1'b0;
            sr        <= '0;
            cnt       <= '0;
            wait_cnt  <= '0;
            pix_valid <= 1'b0;
            pix_on    <= 1'b0;
            pix_col   <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_next;
            if (load_req) begin
                rom_addr <= {tile_id, row};
                flip     <= flip_h;
            end
            if (wait_clr) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (capture) begin
                sr  <= rom_data;
                cnt <= '0;
            end
            // Flip only changes which end of the word is emitted; sr always moves toward it.
            if (emit) begin
                pix_on  <= flip ? sr[0] : sr[DATA_WIDTH-1];
                pix_col <= cnt;
                sr      <= flip ? (sr >> 1) : (sr << 1);
                cnt     <= cnt + 1'b1;
            end
            pix_valid <= emit;
            done      <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_sprite_row_reader.sv
// Directed bench for sprite_row_reader with combinational (ROM_LAT=0) and registered (ROM_LAT=1) ROM models.
module tb_sprite_row_reader;
    import sprite_pkg::*;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset, start, flip_h, pix_en;
    logic [0:0]  tile_id;
    logic [4:0]  row;

    logic [5:0]  rom_addr0, rom_addr1;
    logic [31:0] rom_data0, rom_data1;
    logic        pv0, po0, busy0, done0;
    logic        pv1, po1, busy1, done1;
    logic [4:0]  pc0, pc1;

    logic        use_ovr;
    logic [31:0] ovr_word;
    int          sel;

    logic        o_pv, o_po, o_busy, o_done;
    logic [4:0]  o_pc;
    logic [5:0]  o_addr;

    int errors = 0;
    int checks = 0;

    sprite_row_reader #(.TILE_BITS(1), .ROW_BITS(5), .DATA_WIDTH(32), .ROM_LAT(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .start(start), .tile_id(tile_id), .row(row),
        .flip_h(flip_h), .pix_en(pix_en), .rom_addr(rom_addr0), .rom_data(rom_data0),
        .pix_valid(pv0), .pix_on(po0), .pix_col(pc0), .busy(busy0), .done(done0)
    );

    sprite_row_reader #(.TILE_BITS(1), .ROW_BITS(5), .DATA_WIDTH(32), .ROM_LAT(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .start(start), .tile_id(tile_id), .row(row),
        .flip_h(flip_h), .pix_en(pix_en), .rom_addr(rom_addr1), .rom_data(rom_data1),
        .pix_valid(pv1), .pix_on(po1), .pix_col(pc1), .busy(busy1), .done(done1)
    );

    // Wall tile: solid top/bottom rows, side borders elsewhere. Floor row 1 is a stripe pattern.
    function automatic logic [31:0] rom_word(input logic [5:0] a);
        logic [4:0] r;
        r = a[4:0];
        if (a[5] == 1'(TILE_WALL)) begin
            return (r == 5'd0 || r == 5'd31) ? 32'hFFFF_FFFF : 32'h8000_0001;
        end
        return (r == 5'd1) ? 32'b00000111111110000001111111100000 : 32'h0F0F_0F0F;
    endfunction

    always_comb rom_data0 = use_ovr ? ovr_word : rom_word(rom_addr0);
    always @(posedge Clk) rom_data1 <= use_ovr ? ovr_word : rom_word(rom_addr1);

    always_comb begin
        if (sel == 1) begin
            o_pv = pv1; o_po = po1; o_busy = busy1; o_done = done1; o_pc = pc1; o_addr = rom_addr1;
        end else begin
            o_pv = pv0; o_po = po0; o_busy = busy0; o_done = done0; o_pc = pc0; o_addr = rom_addr0;
        end
    end

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Edge 0 samples start; every later edge e is observed at the following negedge.
    task automatic run_row(input int s, input logic [0:0] t, input logic [4:0] r, input logic f,
                           input logic [31:0] word, input int period, input int first_exp,
                           input bit inj, input string tag);
        int npix, first, last, doneat;
        logic [5:0] a;
        logic       bitv;
        a = {t, r};
        sel = s;
        npix = 0; first = -1; last = -1; doneat = -1;
        tile_id = t; row = r; flip_h = f; start = 1'b1; pix_en = (period == 1);
        step();
        for (int e = 1; e <= 200 && doneat < 0; e++) begin
            start   = inj && (e == 10 || npix == 32);
            tile_id = inj ? ~t : t;
            row     = inj ? ~r : r;
            pix_en  = (e % period == 0);
            step();
            if (e == 1) begin
                chk({tag, "_addr"}, 64'(o_addr), 64'(a));
                chk({tag, "_busy"}, 64'(o_busy), 64'd1);
            end
            if (o_pv) begin
                if (npix < 32) begin
                    bitv = f ? word[npix] : word[31 - npix];
                    chk({tag, "_pix"}, 64'({pix_en, o_pc, o_po}), 64'({1'b1, npix[4:0], bitv}));
                end
                npix++;
                if (first < 0) first = e;
                last = e;
            end
            if (o_done) doneat = e;
        end
        start = 1'b0; tile_id = t; row = r;
        chk({tag, "_npix"},  64'(npix),   64'd32);
        chk({tag, "_first"}, 64'(first),  64'(first_exp));
        chk({tag, "_last"},  64'(last),   64'(first_exp + 31 * period));
        chk({tag, "_done"},  64'(doneat), 64'(last + 1));
        pix_en = 1'b1;
        step();
        chk({tag, "_after"}, 64'({o_done, o_busy, o_addr}), 64'({1'b0, 1'b0, a}));
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic reset_mid(input int s, input int first_exp, input string tag);
        int  npix;
        bit  seen;
        sel = s;
        tile_id = 1'b0; row = 5'd5; flip_h = 1'b0; pix_en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        npix = 0;
        for (int e = 1; e <= 100 && npix < 10; e++) begin
            step();
            if (o_pv) npix++;
        end
        chk({tag, "_pre"}, 64'(npix), 64'd10);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk({tag, "_rst"}, 64'({o_addr, o_pv, o_po, o_pc, o_busy, o_done}), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (o_done || o_busy) seen = 1'b1;
        end
        chk({tag, "_quiet"}, 64'(seen), 64'd0);
        run_row(s, 1'b0, 5'd5, 1'b0, 32'h8000_0001, 1, first_exp, 1'b0, {tag, "_new"});
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; flip_h = 1'b0; pix_en = 1'b0;
        tile_id = 1'b0; row = 5'd0; use_ovr = 1'b0; ovr_word = 32'h0; sel = 0;
        step();
        step();
        Reset = 1'b0;
        chk("reset0", 64'({rom_addr0, pv0, po0, pc0, busy0, done0}), 64'd0);
        chk("reset1", 64'({rom_addr1, pv1, po1, pc1, busy1, done1}), 64'd0);

        run_row(0, 1'b0, 5'd0, 1'b0, 32'hFFFF_FFFF, 1, 2, 1'b0, "t1_row0");
        run_row(0, 1'b0, 5'd5, 1'b0, 32'h8000_0001, 1, 2, 1'b0, "t2_row5");

        use_ovr = 1'b1; ovr_word = 32'hF000_0000;
        run_row(0, 1'b0, 5'd3, 1'b1, 32'hF000_0000, 1, 2, 1'b0, "t3_flip");
        run_row(0, 1'b0, 5'd3, 1'b0, 32'hF000_0000, 1, 2, 1'b0, "t3_noflip");
        use_ovr = 1'b0;

        run_row(0, 1'b1, 5'd1, 1'b0, 32'b00000111111110000001111111100000, 2, 2, 1'b0, "t4_half");
        run_row(0, 1'b0, 5'd5, 1'b0, 32'h8000_0001, 1, 2, 1'b1, "t5_ignore");

        reset_mid(0, 2, "t6_lat0");
        reset_mid(1, 3, "t6_lat1");
        run_row(1, 1'b1, 5'd1, 1'b1, 32'b00000111111110000001111111100000, 1, 3, 1'b0, "t6_lat1_flip");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
